// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider.
// Each channel divides clk_in by a runtime ratio N held in an active register.
// New ratios are written to a shadow register and promoted to active only at a
// period boundary (wrap), at a sync pulse, or immediately while the channel is
// stopped, so a running output never sees a truncated or stretched phase.
module clk_div_multi #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 1000,
    localparam int CH_AW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              cfg_wr,
    input  logic [CH_AW-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] cfg_pending
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    // Per-channel state
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [CNT_W-1:0]  r_act [NUM_CH];
    logic [CNT_W-1:0]  r_shd [NUM_CH];
    logic [NUM_CH-1:0] r_pending;
    logic [NUM_CH-1:0] r_clk_out;
    logic [NUM_CH-1:0] r_tick;

    // Per-channel decode
    logic [NUM_CH-1:0] w_running;  // enabled and ratio usable (N >= 2)
    logic [NUM_CH-1:0] w_wrap;     // last cycle of the current period
    logic [NUM_CH-1:0] w_wr_hit;   // config write addressed to this channel
    logic [NUM_CH-1:0] w_apply;    // shadow ratio promoted to active this cycle
    logic [NUM_CH-1:0] w_hi;       // counter in the high half of the period

    // Decode run state, period boundary and shadow promotion for every channel
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned, which would infer a latch.
        w_running = '0;
        w_wrap    = '0;
        w_wr_hit  = '0;
        w_apply   = '0;
        w_hi      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_running[i] = ch_en[i] && (r_act[i] >= TWO);
            w_wrap[i]    = w_running[i] && (r_cnt[i] == r_act[i] - ONE);
            // Channel numbers >= NUM_CH match no channel, so such writes vanish.
            w_wr_hit[i]  = cfg_wr && (int'(cfg_ch) == i);
            // A boundary is a wrap, a sync, or any cycle the channel is stopped.
            w_apply[i]   = r_pending[i] && (sync || w_wrap[i] || !w_running[i]);
            w_hi[i]      = r_cnt[i] < (r_act[i] >> 1);
        end
    end

    // Counters, ratio registers and registered outputs
    always_ff @(posedge clk_in) begin
        // NOTE: state is updated with non-blocking assignments so every
        // channel sees the pre-edge values regardless of statement order.
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i] <= '0;
                r_act[i] <= DEF_DIV;
                r_shd[i] <= DEF_DIV;
            end
            r_pending <= '0;
            r_clk_out <= '0;
            r_tick    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // Counter restarts on sync, on wrap, and is parked while stopped.
                if (sync || w_wrap[i] || !w_running[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + ONE;
                end

                // sync wins over a coincident wrap, so the tick is dropped.
                r_tick[i]    <= w_wrap[i] && !sync;
                r_clk_out[i] <= w_running[i] && w_hi[i];

                // Promotion uses the shadow value from before this edge, so a
                // simultaneous write lands in the shadow and stays pending.
                if (w_apply[i]) begin
                    r_act[i] <= r_shd[i];
                end

                if (w_wr_hit[i]) begin
                    r_shd[i]     <= cfg_div;
                    r_pending[i] <= 1'b1;
                end else if (w_apply[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    assign clk_out     = r_clk_out;
    assign tick        = r_tick;
    assign cfg_pending = r_pending;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed testbench for clk_div_multi: default ratio, deferred ratio update,
// odd and degenerate ratios, sync alignment, write/wrap collision, reset abort
// and out-of-range channel writes (on a 3-channel instance).
module tb_clk_div_multi;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       cfg_wr;
    logic       cfg_ch;
    logic [15:0] cfg_div;
    logic [1:0] ch_en;
    logic       sync;
    logic [1:0] clk_out;
    logic [1:0] tick;
    logic [1:0] cfg_pending;

    // Second instance with three channels so an out-of-range channel exists
    logic       cfg_wr3;
    logic [1:0] cfg_ch3;
    logic [7:0] cfg_div3;
    logic [2:0] clk_out3;
    logic [2:0] tick3;
    logic [2:0] cfg_pending3;

    int n_checks = 0;
    int n_errors = 0;

    clk_div_multi #(.NUM_CH(2), .CNT_W(16), .DEFAULT_DIV(1000)) u_dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .ch_en       (ch_en),
        .sync        (sync),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    clk_div_multi #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) u_dut3 (
        .clk_in      (clk_in),
        .reset       (reset),
        .cfg_wr      (cfg_wr3),
        .cfg_ch      (cfg_ch3),
        .cfg_div     (cfg_div3),
        .ch_en       (3'b111),
        .sync        (1'b0),
        .clk_out     (clk_out3),
        .tick        (tick3),
        .cfg_pending (cfg_pending3)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled and inputs changed 1 ns later.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    logic [17:0] pat_clk, pat_tick, pat_clk1, pat_tick1;
    logic [7:0]  pat3_0, pat3_1, pat3_2;
    logic        any_out;
    int          hi0, hi1, n_tick, first_tick;

    initial begin
        reset = 1'b1; cfg_wr = 1'b0; cfg_ch = 1'b0; cfg_div = '0;
        ch_en = 2'b11; sync = 1'b0;
        cfg_wr3 = 1'b0; cfg_ch3 = '0; cfg_div3 = '0;

        // ---- 1: reset state and default ratio 1000 ----
        repeat (3) step();
        check("reset_clk_out", clk_out, 2'b00);
        check("reset_tick", tick, 2'b00);
        check("reset_pending", cfg_pending, 2'b00);
        reset = 1'b0;
        hi0 = 0; hi1 = 0; n_tick = 0; first_tick = -1;
        for (int k = 0; k < 2000; k++) begin
            step();
            hi0 += int'(clk_out[0]);
            hi1 += int'(clk_out[1]);
            if (tick[0]) begin
                n_tick++;
                if (first_tick < 0) first_tick = k;
            end
            if (k == 0)   check("def_first_high", clk_out, 2'b11);
            if (k == 499) check("def_last_high", clk_out, 2'b11);
            if (k == 500) check("def_first_low", clk_out, 2'b00);
        end
        check("def_high_cnt0", hi0, 1000);
        check("def_high_cnt1", hi1, 1000);
        check("def_tick_cnt", n_tick, 2);
        check("def_first_tick", first_tick, 999);
        check("def_pending", cfg_pending, 2'b00);

        // ---- 2: ch0 at N=10, write N=4 at cnt=3 ----
        ch_en = 2'b10;
        step();
        cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd10;
        step();
        cfg_wr = 1'b0;
        step();                       // stopped channel applies shadow at once
        check("stop_apply_pending", cfg_pending[0], 1'b0);
        ch_en = 2'b11;
        pat_clk = '0; pat_tick = '0;
        for (int j = 0; j < 18; j++) begin
            cfg_wr = (j == 3); cfg_ch = 1'b0; cfg_div = 16'd4;
            step();
            pat_clk  = {pat_clk[16:0], clk_out[0]};
            pat_tick = {pat_tick[16:0], tick[0]};
            if (j == 3) check("n4_pending_set", cfg_pending[0], 1'b1);
            if (j == 8) check("n4_pending_hold", cfg_pending[0], 1'b1);
            if (j == 9) check("n4_pending_clr", cfg_pending[0], 1'b0);
        end
        cfg_wr = 1'b0;
        check("n10_to_n4_clk", pat_clk, 18'b111110000011001100);
        check("n10_to_n4_tick", pat_tick, 18'b000000000100010001);

        // ---- 3: N=5, then N=1, then N=0 ----
        pat_clk = '0; pat_tick = '0;
        for (int j = 18; j < 32; j++) begin
            cfg_wr = (j == 18); cfg_ch = 1'b0; cfg_div = 16'd5;
            step();
            pat_clk  = {pat_clk[16:0], clk_out[0]};
            pat_tick = {pat_tick[16:0], tick[0]};
        end
        check("n5_clk", pat_clk, 14'b11001100011000);
        check("n5_tick", pat_tick, 14'b00010000100001);
        pat_clk = '0; pat_tick = '0;
        for (int j = 32; j < 42; j++) begin
            cfg_wr = (j == 32); cfg_ch = 1'b0; cfg_div = 16'd1;
            step();
            pat_clk  = {pat_clk[16:0], clk_out[0]};
            pat_tick = {pat_tick[16:0], tick[0]};
        end
        cfg_wr = 1'b0;
        check("n1_clk", pat_clk, 10'b1100000000);
        check("n1_tick", pat_tick, 10'b0000100000);
        cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd0;
        step();
        cfg_wr = 1'b0;
        check("n0_pending_set", cfg_pending[0], 1'b1);
        step();
        check("n0_pending_clr", cfg_pending[0], 1'b0);
        any_out = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step();
            any_out = any_out | clk_out[0] | tick[0];
        end
        check("n0_stopped", any_out, 1'b0);

        // ---- 4: ch0 N=6, ch1 N=4, sync alignment ----
        cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd6;
        step();
        cfg_wr = 1'b1; cfg_ch = 1'b1; cfg_div = 16'd4;
        step();
        cfg_wr = 1'b0; sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_apply_pending", cfg_pending, 2'b00);
        check("sync_apply_tick", tick, 2'b00);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 3) check("n4_wrap_tick", tick, 2'b10);
        end
        sync = 1'b1;                  // ch0 at cnt 5 (its wrap), ch1 at cnt 1
        step();
        sync = 1'b0;
        check("sync_tick_suppressed", tick, 2'b00);
        check("sync_edge_clk", clk_out, 2'b10);
        pat_clk = '0; pat_tick = '0; pat_clk1 = '0; pat_tick1 = '0;
        for (int j = 0; j < 12; j++) begin
            step();
            pat_clk   = {pat_clk[16:0], clk_out[0]};
            pat_tick  = {pat_tick[16:0], tick[0]};
            pat_clk1  = {pat_clk1[16:0], clk_out[1]};
            pat_tick1 = {pat_tick1[16:0], tick[1]};
            if (j == 0) check("post_sync_both_high", clk_out, 2'b11);
        end
        check("sync_ch0_clk", pat_clk, 12'b111000111000);
        check("sync_ch0_tick", pat_tick, 12'b000001000001);
        check("sync_ch1_clk", pat_clk1, 12'b110011001100);
        check("sync_ch1_tick", pat_tick1, 12'b000100010001);

        // ---- 5: write N=8 to ch1 in its wrap cycle while 6 is pending ----
        pat_clk1 = '0; pat_tick1 = '0;
        for (int j = 12; j < 30; j++) begin
            cfg_wr = (j == 12) || (j == 15);
            cfg_ch = 1'b1;
            cfg_div = (j == 12) ? 16'd6 : 16'd8;
            step();
            pat_clk1  = {pat_clk1[16:0], clk_out[1]};
            pat_tick1 = {pat_tick1[16:0], tick[1]};
            if (j == 12) check("col_pending_w6", cfg_pending[1], 1'b1);
            if (j == 15) check("col_pending_wrap", cfg_pending[1], 1'b1);
            if (j == 20) check("col_pending_hold", cfg_pending[1], 1'b1);
            if (j == 21) check("col_pending_clr", cfg_pending[1], 1'b0);
        end
        cfg_wr = 1'b0;
        check("col_ch1_clk", pat_clk1, 18'b110011100011110000);
        check("col_ch1_tick", pat_tick1, 18'b000100000100000001);

        // ---- 6: reset mid-period with a pending ratio ----
        cfg_wr = 1'b1; cfg_ch = 1'b1; cfg_div = 16'd3;
        step();
        cfg_wr = 1'b0;
        step();
        check("pre_reset_pending", cfg_pending[1], 1'b1);
        reset = 1'b1;
        cfg_wr = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd5;   // write during reset is dropped
        step();
        reset = 1'b0; cfg_wr = 1'b0;
        check("rst_mid_clk_out", clk_out, 2'b00);
        check("rst_mid_tick", tick, 2'b00);
        check("rst_mid_pending", cfg_pending, 2'b00);
        check("rst_mid_pending3", cfg_pending3, 3'b000);
        hi0 = 0; hi1 = 0; first_tick = -1;
        pat3_0 = '0; pat3_1 = '0; pat3_2 = '0;
        for (int k = 0; k < 1000; k++) begin
            cfg_wr3  = (k == 1) || (k == 2);
            cfg_ch3  = (k == 1) ? 2'd3 : 2'd2;
            cfg_div3 = 8'd2;
            step();
            hi0 += int'(clk_out[0]);
            hi1 += int'(clk_out[1]);
            if (tick[1] && first_tick < 0) first_tick = k;
            if (k < 8) begin
                pat3_0 = {pat3_0[6:0], clk_out3[0]};
                pat3_1 = {pat3_1[6:0], clk_out3[1]};
                pat3_2 = {pat3_2[6:0], clk_out3[2]};
            end
            if (k == 1) check("oor_write_ignored", cfg_pending3, 3'b000);
            if (k == 2) check("inrange_write_pending", cfg_pending3, 3'b100);
            if (k == 3) check("inrange_write_applied", cfg_pending3, 3'b000);
            if (k == 500) check("rst_def_low", clk_out, 2'b00);
        end
        cfg_wr3 = 1'b0;
        check("rst_def_high0", hi0, 500);
        check("rst_def_high1", hi1, 500);
        check("rst_def_first_tick", first_tick, 999);
        check("oor_ch0_clk", pat3_0, 8'b11001100);
        check("oor_ch1_clk", pat3_1, 8'b11001100);
        check("inrange_ch2_clk", pat3_2, 8'b11001010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
